control_debouncer: RTL and testbench
====================================

# control_debouncer

Conditions raw `control` button/sensor inputs before they drive gate modules in `main`. Each of `WIDTH` independent channels is synchronised, then debounced by a four-state FSM. The block outputs a clean level, single-cycle rise/fall strobes and a push-on/push-off toggle level. It sits directly upstream of the combinational modules, for example on the `a`/`b` inputs of a two-input gate module.

## Interface
- `WIDTH`, 2: number of independent channels.
- `STABLE_CYCLES`, 4: consecutive identical synchronised samples required to accept a new level; legal range 2..255.
- `CNT_W`, 8: debounce counter width; must hold `STABLE_CYCLES-1`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `raw` in WIDTH: unsynchronised control inputs; bit i is channel i.
- `level` out WIDTH: debounced level per channel.
- `rise` out WIDTH: one-cycle pulse when `level[i]` goes 0→1.
- `fall` out WIDTH: one-cycle pulse when `level[i]` goes 1→0.
- `toggle` out WIDTH: per-channel latch that inverts on every `rise[i]`.

## Operation
- Per channel, a two-flop synchroniser: `s1 <= raw[i]`, `s2 <= s1`. The FSM sees only `s2`.
- Per channel, the FSM uses states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, plus counter `cnt`:
  - STABLE_LO: `s2=1` → WAIT_HI, `cnt<=1`; else stay.
  - WAIT_HI: `s2=0` → STABLE_LO, `cnt<=0` (bounce rejected, no strobe). If `s2=1` and `cnt==STABLE_CYCLES-1` → STABLE_HI, `cnt<=0`, `level<=1`, `rise<=1`, `toggle<=~toggle`. Otherwise `cnt<=cnt+1`.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted; acceptance drives `level<=0`, `fall<=1`, and leaves `toggle` unchanged.
- `rise` and `fall` are registered and high for exactly one cycle. They are never both high in one channel, and are never high on consecutive cycles in one channel.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- `cnt` never exceeds `STABLE_CYCLES-1`; no wrap-around is reachable.

## Timing
- Reset: when `rst` is sampled high, then after that edge `s1`, `s2`, `level`, `rise`, `fall` and `toggle` are all 0, state = STABLE_LO and `cnt`=0. `rst` overrides all other activity.
- Reset mid-bounce abandons the pending transition; no strobe is emitted.
- Latency: suppose `raw[i]` is sampled at a new value on edges k..k+S-1, where S=`STABLE_CYCLES`. Then `level[i]` and the strobe update on edge k+S+1, and the strobe clears on edge k+S+2.
- If `raw` is held high through reset, it is treated as a new rising event. With e = first edge at which `rst` is low, `level` and `rise` assert at edge e+S+1.
- A pulse shorter than S samples produces no output change and no strobe.
- There is no input handshake: `raw` may change on any cycle, and outputs are valid every cycle.

## Test plan
- Reset: `raw=2'b11` held, `rst=1` for 3 cycles → all outputs 0 during reset; with S=4, `level=2'b11`, `rise=2'b11` and `toggle=2'b11` at e+5; `rise=0` at e+6.
- Clean press: `raw[0]` 0→1 at edge 10, held → `level[0]=1` and `rise[0]=1` after edge 15 only; `fall[0]`=0 throughout.
- Bounce reject: `raw[0]` pattern 1,1,1,0 repeated for 20 cycles, then 0 → `level[0]` stays 0, no `rise`, `toggle[0]` unchanged.
- Toggle: three clean presses/releases on `raw[1]`, each 8 cycles high and 8 low → `toggle[1]` sequence 1,0,1; 3 `rise` and 3 `fall` pulses.
- Simultaneous: `raw` 00→11 on the same edge → `rise=2'b11` in one cycle. Later `raw[0]` falls while `raw[1]` stays high → `fall=2'b01` only.
- Mid-bounce reset: `raw[0]=1` for 3 cycles, `rst=1` for 1 cycle, `raw[0]` held → no `rise` before e+5; exactly one `rise` at e+5.

Source files
------------

// File: rtl/control_debouncer_if.sv
// Bundles the raw control inputs and the conditioned outputs of the debouncer.
// master: the block that drives raw inputs and consumes the conditioned outputs.
// slave:  the debouncer itself.
interface control_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] toggle;

    modport master (
        output raw,
        input  level,
        input  rise,
        input  fall,
        input  toggle
    );

    modport slave (
        input  raw,
        output level,
        output rise,
        output fall,
        output toggle
    );
endinterface

// File: rtl/control_debouncer.sv
// Per-channel synchroniser plus four-state debounce FSM for raw button/sensor
// inputs. Each channel produces a clean level, one-cycle rise/fall strobes and
// a push-on/push-off toggle level. Channels are completely independent.
module control_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    control_debouncer_if.slave bus
);
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // Value of cnt on the sample that completes a run of STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] toggle_vec;

    // Two-flop synchroniser; the FSMs only ever look at s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             accept_hi;
        logic             accept_lo;
        logic             level_r;
        logic             rise_r;
        logic             fall_r;
        logic             toggle_r;
        logic             level_next;
        logic             rise_next;
        logic             fall_next;
        logic             toggle_next;

        // State, counter and registered outputs; reset abandons any pending transition.
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= STABLE_LO;
                cnt      <= '0;
                level_r  <= 1'b0;
                rise_r   <= 1'b0;
                fall_r   <= 1'b0;
                toggle_r <= 1'b0;
            end else begin
                state    <= state_next;
                cnt      <= cnt_next;
                level_r  <= level_next;
                rise_r   <= rise_next;
                fall_r   <= fall_next;
                toggle_r <= toggle_next;
            end
        end

        // Next-state logic: a new level is accepted only after an unbroken run
        // of identical samples; any opposite sample falls back to the stable state.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            accept_hi  = 1'b0;
            accept_lo  = 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s2[i]) begin
                        state_next = WAIT_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s2[i]) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                        accept_hi  = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2[i]) begin
                        state_next = WAIT_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (s2[i]) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                        accept_lo  = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end
            endcase
        end

        // Output logic: strobes last one cycle, toggle flips only on acceptance of a high level.
        always_comb begin
            rise_next   = accept_hi;
            fall_next   = accept_lo;
            level_next  = level_r;
            toggle_next = toggle_r;
            if (accept_hi) begin
                level_next  = 1'b1;
                toggle_next = ~toggle_r;
            end else if (accept_lo) begin
                level_next  = 1'b0;
            end
        end

        assign level_vec[i]  = level_r;
        assign rise_vec[i]   = rise_r;
        assign fall_vec[i]   = fall_r;
        assign toggle_vec[i] = toggle_r;
    end

    assign bus.level  = level_vec;
    assign bus.rise   = rise_vec;
    assign bus.fall   = fall_vec;
    assign bus.toggle = toggle_vec;
endmodule

// File: tb/tb_control_debouncer.sv
// Directed self-checking bench for control_debouncer (WIDTH=2, STABLE_CYCLES=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_control_debouncer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    control_debouncer_if #(.WIDTH(2)) bus ();

    control_debouncer #(
        .WIDTH(2),
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.raw = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        logic [1:0] exp_level;
        logic [1:0] exp_rise;
        bus.raw = 2'b11;
        rst     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            n_checks++;
            if ({bus.level, bus.rise, bus.fall, bus.toggle} !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: got %b expected %b",
                         {bus.level, bus.rise, bus.fall, bus.toggle}, 8'h00);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            exp_level = (c >= 5) ? 2'b11 : 2'b00;
            exp_rise  = (c == 5) ? 2'b11 : 2'b00;
            n_checks++;
            if (bus.level !== exp_level) begin
                n_fail++;
                $display("[TB] FAIL reset_held_level c=%0d: got %b expected %b", c, bus.level, exp_level);
            end
            n_checks++;
            if (bus.rise !== exp_rise) begin
                n_fail++;
                $display("[TB] FAIL reset_held_rise c=%0d: got %b expected %b", c, bus.rise, exp_rise);
            end
            n_checks++;
            if (bus.toggle !== exp_level) begin
                n_fail++;
                $display("[TB] FAIL reset_held_toggle c=%0d: got %b expected %b", c, bus.toggle, exp_level);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        bus.raw = 2'b01;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            n_checks++;
            if (bus.level[0] !== (c >= 5)) begin
                n_fail++;
                $display("[TB] FAIL press_level c=%0d: got %b expected %b", c, bus.level[0], (c >= 5));
            end
            n_checks++;
            if (bus.rise[0] !== (c == 5)) begin
                n_fail++;
                $display("[TB] FAIL press_rise c=%0d: got %b expected %b", c, bus.rise[0], (c == 5));
            end
            n_checks++;
            if (bus.fall[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL press_fall c=%0d: got %b expected 0", c, bus.fall[0]);
            end
        end
        bus.raw = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            n_checks++;
            if (bus.fall[0] !== (c == 5) || bus.rise[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL release_strobes c=%0d: got fall=%b rise=%b expected fall=%b rise=0",
                         c, bus.fall[0], bus.rise[0], (c == 5));
            end
        end
        n_checks++;
        if (bus.level[0] !== 1'b0 || bus.toggle[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release_final: got level=%b toggle=%b expected level=0 toggle=1",
                     bus.level[0], bus.toggle[0]);
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            bus.raw = {1'b0, ((c % 4) != 3)};
            tick(1);
            n_checks++;
            if (bus.level[0] !== 1'b0 || bus.rise[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bounce_reject c=%0d: got level=%b rise=%b expected 0 0",
                         c, bus.level[0], bus.rise[0]);
            end
        end
        bus.raw = 2'b00;
        tick(6);
        n_checks++;
        if (bus.toggle[0] !== 1'b1 || bus.level[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bounce_final: got toggle=%b level=%b expected toggle=1 level=0",
                     bus.toggle[0], bus.level[0]);
        end
    endtask

    task automatic test_toggle();
        int rises;
        int falls;
        rises = 0;
        falls = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            bus.raw = 2'b10;
            for (int c = 0; c < 8; c++) begin
                tick(1);
                if (bus.rise[1] === 1'b1) rises++;
                if (bus.fall[1] === 1'b1) falls++;
            end
            n_checks++;
            if (bus.toggle[1] !== ((p % 2) == 0)) begin
                n_fail++;
                $display("[TB] FAIL toggle_value press=%0d: got %b expected %b", p, bus.toggle[1], ((p % 2) == 0));
            end
            bus.raw = 2'b00;
            for (int c = 0; c < 8; c++) begin
                tick(1);
                if (bus.rise[1] === 1'b1) rises++;
                if (bus.fall[1] === 1'b1) falls++;
            end
        end
        n_checks++;
        if (rises != 3 || falls != 3) begin
            n_fail++;
            $display("[TB] FAIL toggle_strobe_count: got rises=%0d falls=%0d expected 3 3", rises, falls);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_strobe;
        bus.raw = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            exp_strobe = (c == 5) ? 2'b11 : 2'b00;
            n_checks++;
            if (bus.rise !== exp_strobe || bus.fall !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL simul_rise c=%0d: got rise=%b fall=%b expected rise=%b fall=00",
                         c, bus.rise, bus.fall, exp_strobe);
            end
        end
        bus.raw = 2'b10;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            exp_strobe = (c == 5) ? 2'b01 : 2'b00;
            n_checks++;
            if (bus.fall !== exp_strobe || bus.rise !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL simul_fall c=%0d: got fall=%b rise=%b expected fall=%b rise=00",
                         c, bus.fall, bus.rise, exp_strobe);
            end
        end
        n_checks++;
        if (bus.level !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL simul_level: got %b expected 10", bus.level);
        end
    endtask

    task automatic test_mid_bounce_reset();
        int rises;
        rises = 0;
        do_reset();
        bus.raw = 2'b01;
        tick(3);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (bus.rise !== 2'b00 || bus.level !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midreset_cleared: got rise=%b level=%b expected 00 00", bus.rise, bus.level);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (bus.rise[0] === 1'b1) rises++;
            n_checks++;
            if (bus.rise[0] !== (c == 5) || bus.level[0] !== (c >= 5)) begin
                n_fail++;
                $display("[TB] FAIL midreset_timing c=%0d: got rise=%b level=%b expected rise=%b level=%b",
                         c, bus.rise[0], bus.level[0], (c == 5), (c >= 5));
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("[TB] FAIL midreset_rise_count: got %0d expected 1", rises);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.raw  = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_toggle();
        test_simultaneous();
        test_mid_bounce_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
